// File: rtl/ise_pkg.sv
// rtl/ise_pkg.sv - shared widths, colour codes and scheduler state encoding for the ISE block
package ise_pkg;

    localparam int IMG_W   = 5;
    localparam int PIX_W   = 14;
    localparam int RGB_W   = 24;
    localparam int NUM_IMG = 32;
    localparam int RES_W   = IMG_W + 2;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DRAIN   = 3'd2,
        ACK     = 3'd3,
        COLLECT = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/ise_result_buf.sv
// rtl/ise_result_buf.sv - 32x7 sorted-result register file, synchronous write, combinational read
module ise_result_buf
    import ise_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IMG_W-1:0] waddr,
    input  logic [RES_W-1:0] wdata,
    input  logic [IMG_W-1:0] raddr,
    output logic [RES_W-1:0] rdata
);

    logic [RES_W-1:0] mem [NUM_IMG];

    // contents need no reset: every rank is rewritten before a job reports done
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ise_frame_scheduler.sv
// rtl/ise_frame_scheduler.sv - ISE job sequencer: frame fetch, core handshake, result capture (option macro: ISE_SCHED_TIMEOUT_EN)
module ise_frame_scheduler
    import ise_pkg::*;
#(
    parameter int PIX_PER_IMG = 16384
`ifdef ISE_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   sched_busy,
    output logic                   done,
    output logic                   mem_rd,
    output logic [IMG_W+PIX_W-1:0] mem_addr,
    input  logic [RGB_W-1:0]       mem_rdata,
    output logic [IMG_W-1:0]       core_image_index,
    output logic [RGB_W-1:0]       core_pixel,
    output logic                   core_pix_valid,
    input  logic                   core_busy,
    input  logic                   core_out_valid,
    input  logic [1:0]             core_color,
    input  logic [IMG_W-1:0]       core_img_out,
    input  logic [IMG_W-1:0]       res_rd_addr,
    output logic [RES_W-1:0]       res_rd_data,
    output logic                   err
);

    state_e           state, state_nxt;
    logic [IMG_W-1:0] img_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [IMG_W-1:0] res_cnt;
    logic             drn_cnt;
    logic             rd_d;
    logic             last_pix;
    logic             last_img;
    logic             start_acc;
    logic             res_we;
    logic             to_fire;

    assign last_pix  = (pix_cnt == PIX_W'(PIX_PER_IMG - 1));
    assign last_img  = (img_cnt == IMG_W'(NUM_IMG - 1));
    assign start_acc = (state == IDLE) && start;
    assign res_we    = (state == COLLECT) && core_out_valid;

    // state-decoded outputs fall to zero with the asynchronous reset
    assign mem_rd           = (state == LOAD);
    assign mem_addr         = mem_rd ? {img_cnt, pix_cnt} : '0;
    assign sched_busy       = (state == LOAD) || (state == DRAIN) || (state == ACK) || (state == COLLECT);
    assign done             = (state == DONE);
    assign core_image_index = img_cnt;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; core_busy and core_out_valid only count in their own states
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (drn_cnt) state_nxt = ACK;
            ACK: begin
                if (core_busy) state_nxt = last_img ? COLLECT : LOAD;
                else if (to_fire) state_nxt = DONE;
            end
            COLLECT: begin
                if (res_we && (res_cnt == IMG_W'(NUM_IMG - 1))) state_nxt = DONE;
                else if (to_fire) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // image, pixel, result and drain counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_cnt <= '0;
            pix_cnt <= '0;
            res_cnt <= '0;
            drn_cnt <= 1'b0;
        end else begin
            if (start_acc) begin
                img_cnt <= '0;
                pix_cnt <= '0;
                res_cnt <= '0;
            end
            if (state == LOAD) begin
                pix_cnt <= last_pix ? '0 : pix_cnt + PIX_W'(1);
                drn_cnt <= 1'b0;
            end
            if (state == DRAIN) begin
                drn_cnt <= 1'b1;
            end
            if ((state == ACK) && core_busy && !last_img) begin
                img_cnt <= img_cnt + IMG_W'(1);
            end
            if (res_we) begin
                res_cnt <= res_cnt + IMG_W'(1);
            end
        end
    end

    // two-stage pixel path: memory returns data one cycle after the strobe, then it is registered to the core
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_d           <= 1'b0;
            core_pix_valid <= 1'b0;
            core_pixel     <= '0;
        end else begin
            rd_d           <= mem_rd;
            core_pix_valid <= rd_d;
            if (rd_d) begin
                core_pixel <= mem_rdata;
            end
        end
    end

`ifdef ISE_SCHED_TIMEOUT_EN
    logic [11:0] wd_cnt;
    logic        err_q;

    assign to_fire = (wd_cnt == 12'(TIMEOUT_CYC - 1)) &&
                     (((state == ACK) && !core_busy) || ((state == COLLECT) && !core_out_valid));
    assign err     = err_q;

    // watchdog restarts on every state change and every captured result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if ((state_nxt != state) || res_we) begin
            wd_cnt <= '0;
        end else if ((state == ACK) || (state == COLLECT)) begin
            wd_cnt <= wd_cnt + 12'd1;
        end
    end

    // sticky error, cleared only by reset or the next accepted job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (to_fire) begin
            err_q <= 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
    assign err     = 1'b0;
`endif

    ise_result_buf u_result_buf (
        .clk   (clk),
        .we    (res_we),
        .waddr (res_cnt),
        .wdata ({core_img_out, core_color}),
        .raddr (res_rd_addr),
        .rdata (res_rd_data)
    );

endmodule

// File: tb/tb_ise_frame_scheduler.sv
// tb/tb_ise_frame_scheduler.sv - randomized self-checking bench for ise_frame_scheduler
module tb_ise_frame_scheduler;

    localparam int PIX  = 128;
    localparam int NIMG = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sched_busy, done, mem_rd, core_pix_valid, err;
    logic [18:0] mem_addr;
    logic [23:0] mem_rdata = '0;
    logic [4:0]  core_image_index;
    logic [23:0] core_pixel;
    logic        core_busy = 1'b0;
    logic        core_out_valid = 1'b0;
    logic [1:0]  core_color = '0;
    logic [4:0]  core_img_out = '0;
    logic [4:0]  res_rd_addr = '0;
    logic [6:0]  res_rd_data;

    int n_chk  = 0;
    int n_fail = 0;
    int dut_reads = 0;
    int align_cd  = 0;

    ise_frame_scheduler #(.PIX_PER_IMG(PIX)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .sched_busy       (sched_busy),
        .done             (done),
        .mem_rd           (mem_rd),
        .mem_addr         (mem_addr),
        .mem_rdata        (mem_rdata),
        .core_image_index (core_image_index),
        .core_pixel       (core_pixel),
        .core_pix_valid   (core_pix_valid),
        .core_busy        (core_busy),
        .core_out_valid   (core_out_valid),
        .core_color       (core_color),
        .core_img_out     (core_img_out),
        .res_rd_addr      (res_rd_addr),
        .res_rd_data      (res_rd_data),
        .err              (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic logic [23:0] pix_fn(logic [18:0] a);
        if (a == 19'h14000) return 24'hFF0000;
        return {3'b000, a[18:14], a[13:0], 2'b00};
    endfunction

    function automatic logic [18:0] addr_of(int k);
        logic [4:0]  im;
        logic [13:0] px;
        im = 5'(k / PIX);
        px = 14'(k % PIX);
        return {im, px};
    endfunction

    // synchronous frame memory: data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= pix_fn(mem_addr);
    end

    // behavioural job model and per-cycle comparison
    bit          m_busy = 0, m_done = 0, m_wait = 0, v1 = 0, v2 = 0;
    int          m_rdleft = 0, m_k = 0, m_acked = 0, m_res = 0;
    logic [18:0] a1 = '0, a2 = '0;
    logic [6:0]  exp_buf [NIMG];

    always @(negedge clk) begin
        bit          erd, acc, nd, nbusy;
        logic [18:0] ea;
        if (!reset) begin
            m_busy = 0; m_done = 0; m_wait = 0; v1 = 0; v2 = 0;
            m_rdleft = 0; m_k = 0; m_acked = 0; m_res = 0; a1 = '0; a2 = '0;
        end else begin
            erd = (m_rdleft > 0);
            ea  = addr_of(m_k);
            chk("sched_busy", sched_busy, m_busy);
            chk("done", done, m_done);
            chk("mem_rd", mem_rd, erd);
            chk("err", err, 0);
            chk("core_pix_valid", core_pix_valid, v2);
            if (erd) chk("mem_addr", mem_addr, ea);
            if (v2) begin
                chk("core_pixel", core_pixel, pix_fn(a2));
                chk("core_image_index", core_image_index, a2[18:14]);
            end
            if (erd) begin
                m_k++;
                m_rdleft--;
                if (m_rdleft == 0) m_wait = 1;
            end
            if (core_busy && m_wait) begin
                m_wait = 0;
                m_acked++;
                if (m_acked < NIMG) m_rdleft = PIX;
            end
            nd = 0;
            if (core_out_valid && m_acked == NIMG && m_res < NIMG) begin
                exp_buf[m_res] = {core_img_out, core_color};
                m_res++;
                if (m_res == NIMG) nd = 1;
            end
            acc   = start && !m_busy && !m_done;
            nbusy = acc || (m_busy && !nd);
            if (acc) begin
                m_rdleft = PIX; m_k = 0; m_acked = 0; m_res = 0; m_wait = 0;
            end
            m_done = nd;
            m_busy = nbusy;
            v2 = v1; v1 = erd;
            a2 = a1; a1 = ea;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (mem_rd) dut_reads++;
        if (align_cd > 0) begin
            align_cd--;
            if (align_cd == 0) begin
                chk("align_pixel", core_pixel, 24'hFF0000);
                chk("align_index", core_image_index, 5);
                chk("align_valid", core_pix_valid, 1);
            end
        end
        if (mem_rd && mem_addr == 19'h14000) align_cd = 2;
    endtask

    // order_mode 0: results 31..0 with fixed ack delay; 1: random permutation and delays
    task automatic run_job(input int long_img, input int order_mode, input bit spurious, input int abort_img);
        int  perm [NIMG];
        int  cnt, guard, d, stall_rd, j, t;
        bit  sp_done;
        sp_done = 0;
        for (int i = 0; i < NIMG; i++) perm[i] = NIMG - 1 - i;
        if (order_mode == 1) begin
            for (int i = NIMG - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
        end
        dut_reads = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_rd", mem_rd, 1);
        chk("first_addr", mem_addr, 0);
        for (int img = 0; img < NIMG; img++) begin
            cnt = 0;
            guard = 0;
            while (cnt < PIX && guard < 4 * PIX) begin
                step();
                guard++;
                if (core_pix_valid) cnt++;
                if (img == abort_img && mem_rd && mem_addr == {5'd10, 14'd100}) begin
                    reset = 1'b0;
                    #1;
                    chk("rst_busy", sched_busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_mem_rd", mem_rd, 0);
                    chk("rst_mem_addr", mem_addr, 0);
                    chk("rst_pix_valid", core_pix_valid, 0);
                    chk("rst_pixel", core_pixel, 0);
                    chk("rst_index", core_image_index, 0);
                    chk("rst_err", err, 0);
                    align_cd = 0;
                    step();
                    step();
                    reset = 1'b1;
                    step();
                    return;
                end
                if (spurious && img == 2 && cnt == 10 && !sp_done) begin
                    sp_done = 1;
                    start = 1'b1;
                    core_out_valid = 1'b1;
                    core_img_out = 5'd7;
                    step();
                    start = 1'b0;
                    core_out_valid = 1'b0;
                    if (core_pix_valid) cnt++;
                    for (int r = 0; r < NIMG; r++) begin
                        res_rd_addr = 5'(r);
                        step();
                        if (core_pix_valid) cnt++;
                        chk("spurious_buf", res_rd_data, exp_buf[r]);
                    end
                end
            end
            if (cnt < PIX) begin
                chk("pixel_count", cnt, PIX);
                return;
            end
            if (img == long_img) d = 1000;
            else if (order_mode == 0) d = 3;
            else d = $urandom_range(1, 6);
            stall_rd = 0;
            repeat (d) begin
                step();
                if (mem_rd) stall_rd++;
            end
            chk("stall_rd", stall_rd, 0);
            core_busy = 1'b1;
            step();
            core_busy = 1'b0;
            if (img < NIMG - 1) chk("resume_rd", mem_rd, 1);
        end
        for (int r = 0; r < NIMG; r++) begin
            if (order_mode == 1) repeat ($urandom_range(0, 3)) step();
            core_out_valid = 1'b1;
            core_img_out = 5'(perm[r]);
            core_color = 2'($urandom_range(0, 2));
            step();
            core_out_valid = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("busy_drop", sched_busy, 0);
        chk("total_reads", dut_reads, NIMG * PIX);
        step();
        chk("done_once", done, 0);
        for (int r = 0; r < NIMG; r++) begin
            res_rd_addr = 5'(r);
            step();
            chk("res_rank", res_rd_data, exp_buf[r]);
            if (order_mode == 0) chk("res_img_rev", res_rd_data[6:2], NIMG - 1 - r);
        end
    endtask

    initial begin
        step();
        step();
        chk("reset_busy", sched_busy, 0);
        chk("reset_done", done, 0);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_pix_valid", core_pix_valid, 0);
        chk("reset_pixel", core_pixel, 0);
        chk("reset_index", core_image_index, 0);
        chk("reset_err", err, 0);
        reset = 1'b1;
        step();
        step();
        run_job(-1, 0, 0, -1);
        run_job(7, 1, 0, -1);
        run_job(-1, 1, 1, -1);
        run_job(-1, 1, 0, 10);
        run_job(-1, 0, 0, -1);
        run_job(-1, 1, 0, -1);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "simulation time limit");
    end

endmodule
